// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encoding,
// opcodes and the datapath select encodings driven by the main FSM.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_EXECUTEI = 4'd8,
        ST_JAL      = 4'd9,
        ST_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_deco.sv
// Immediate-format select, decoded purely from the opcode so the immediate
// extender is valid in every cycle (DECODE uses it for the branch target).
module imm_src_deco
    import riscv_mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] immSrc
);

    always_comb begin
        immSrc = IMM_I;
        case (op)
            OP_SW:   immSrc = IMM_S;
            OP_BEQ:  immSrc = IMM_B;
            OP_JAL:  immSrc = IMM_J;
            default: immSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main Moore control FSM of the multicycle RV32I core: sequences the shared
// ALU, memory port and instruction registers one state per clock.
module multicycle_ctrl_fsm
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] immSrc,
    output logic       regWrite
);

    state_t state_q;
    state_t state_d;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_R:         state_d = ST_EXECUTER;
                    OP_I:         state_d = ST_EXECUTEI;
                    OP_JAL:       state_d = ST_JAL;
                    OP_BEQ:       state_d = ST_BEQ;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:   state_d = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: state_d = ST_FETCH;
            ST_EXECUTER: state_d = ST_ALUWB;
            ST_EXECUTEI: state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
            ST_BEQ:      state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; unused encodings fall through to all-zero.
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        resultSrc = RES_ALUOUT;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_REGB;
        aluOp     = ALUOP_ADD;
        regWrite  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                irWrite   = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURESULT;
                pc_update = 1'b1;
            end
            ST_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            ST_MEMADR: begin
                aluSrcA = SRCA_REGA;
                aluSrcB = SRCB_IMM;
            end
            ST_MEMREAD: begin
                adrSrc = 1'b1;
            end
            ST_MEMWB: begin
                resultSrc = RES_DATA;
                regWrite  = 1'b1;
            end
            ST_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            ST_EXECUTER: begin
                aluSrcA = SRCA_REGA;
                aluOp   = ALUOP_FUNCT;
            end
            ST_EXECUTEI: begin
                aluSrcA = SRCA_REGA;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                regWrite = 1'b1;
            end
            ST_JAL: begin
                aluSrcA   = SRCA_OLDPC;
                aluSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            ST_BEQ: begin
                aluSrcA = SRCA_REGA;
                aluOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    // zero is a same-cycle ALU result, so a taken beq loads PC at the end of BEQ.
    assign pcWrite = pc_update | (branch & zero);

    imm_src_deco u_imm_src_deco (
        .op     (op),
        .immSrc (immSrc)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: directed instructions plus a random instruction stream,
// each cycle compared against an instruction-step reference model.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] immSrc;
    logic       regWrite;

    int vectors;
    int miscompares;

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .pcWrite   (pcWrite),
        .adrSrc    (adrSrc),
        .memWrite  (memWrite),
        .irWrite   (irWrite),
        .resultSrc (resultSrc),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .aluOp     (aluOp),
        .immSrc    (immSrc),
        .regWrite  (regWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    // {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, aluOp, immSrc, regWrite}
    function automatic logic [14:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] ao,
                                       input logic [1:0] im, input logic rw);
        return {pcw, adr, mw, irw, rs, sa, sb, ao, im, rw};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int instr_len(input logic [6:0] o);
        if (o == LW) return 5;
        if (o == SW || o == RT || o == IT || o == JAL) return 4;
        if (o == BEQ) return 3;
        return 2;
    endfunction

    // Expected outputs in cycle 'step' of an instruction, counted from its fetch.
    function automatic logic [14:0] expect_out(input logic [6:0] o, input int step, input logic z);
        logic [1:0] im;
        im = imm_of(o);
        if (step == 0) return pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, im, 0);
        if (step == 1) return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 0);
        if (o == LW || o == SW) begin
            if (step == 2) return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0);
            if (o == LW && step == 3) return pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
            if (o == LW) return pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, im, 1);
            return pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
        end
        if (step == 3) return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1);
        if (o == RT)  return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, im, 0);
        if (o == IT)  return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, im, 0);
        if (o == JAL) return pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0);
        return pk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, im, 0);
    endfunction

    task automatic check(input string tag, input logic [14:0] exp_v);
        logic [14:0] obs;
        obs = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
               aluOp, immSrc, regWrite};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
        if (memWrite === 1'b1 && regWrite === 1'b1) begin
            miscompares++;
            $error("FAIL %s_excl: observed memWrite=1 regWrite=1 expected not both", tag);
        end
    endtask

    // Runs one instruction from FETCH; zmode 0/1 forces zero, 2 randomizes it.
    // abort_step >= 0 asserts reset partway through that step.
    task automatic run_instr(input logic [6:0] o, input int zmode, input int abort_step);
        int n;
        n = instr_len(o);
        op = o;
        for (int s = 0; s < n; s++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check($sformatf("op%b_step%0d", o, s), expect_out(o, s, zero));
            if (s == abort_step) begin
                #2 reset = 1'b1;
                #1;
                check($sformatf("op%b_async_rst", o), expect_out(o, 0, zero));
                @(posedge clk);
                #1;
                check($sformatf("op%b_rst_edge", o), expect_out(o, 0, zero));
                @(negedge clk);
                reset = 1'b0;
                $display("instr op=%b aborted by reset at step %0d", o, s);
                return;
            end
            @(negedge clk);
        end
        $display("instr op=%b zero_mode=%0d cycles=%0d", o, zmode, n);
    endtask

    initial begin
        logic [6:0] pick;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        op = RT;
        zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_cycle%0d", i), expect_out(RT, 0, 1'b0));
        end
        reset = 1'b0;

        run_instr(RT, 2, -1);
        run_instr(LW, 2, -1);
        run_instr(SW, 2, -1);
        run_instr(BEQ, 1, -1);
        run_instr(BEQ, 0, -1);
        run_instr(JAL, 2, -1);
        run_instr(IT, 2, -1);
        run_instr(7'b1111111, 2, -1);
        run_instr(LW, 2, 2);
        run_instr(SW, 2, 2);
        run_instr(RT, 2, -1);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 6))
                0: pick = LW;
                1: pick = SW;
                2: pick = RT;
                3: pick = IT;
                4: pick = BEQ;
                5: pick = JAL;
                default: pick = 7'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0)
                run_instr(pick, 2, $urandom_range(0, instr_len(pick) - 1));
            else
                run_instr(pick, 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control state machine for the multicycle RV32I subset processor (lw, sw, R-type, I-type ALU, beq, jal). It sequences the shared datapath across cycles:
- one ALU, used for PC+4, branch target, address and result;
- one memory port;
- instruction/data registers.

It generates the per-cycle mux selects, write enables and the 2-bit `aluOp` consumed by the ALU decoder. It sits beside the immediate-select decoder inside the controller, between the instruction register and the datapath.

## Interface
Parameters: none (RV32I opcodes fixed).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  7  instruction opcode, instr[6:0] from instruction register
- zero  in  1  ALU zero flag
- pcWrite  out  1  PC register enable
- adrSrc  out  1  memory address select: 0 PC, 1 result
- memWrite  out  1  data memory write enable
- irWrite  out  1  instruction/oldPC register enable
- resultSrc  out  2  00 aluOut, 01 data, 10 aluResult
- aluSrcA  out  2  00 PC, 01 oldPC, 10 regA
- aluSrcB  out  2  00 regB, 01 immExt, 10 const 4
- aluOp  out  2  00 add, 01 subtract (beq), 10 funct-decoded
- immSrc  out  2  00 I, 01 S, 10 B, 11 J (combinational from op)
- regWrite  out  1  register file write enable

## Operation
- Moore FSM, 4-bit state register. All outputs are decoded from state only, except:
  - pcWrite = pcUpdate | (branch & zero);
  - immSrc = f(op).
- Every output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH (0): adrSrc0, irWrite1, aluSrcA00, aluSrcB10, aluOp00, resultSrc10, pcUpdate1 -> DECODE
  - DECODE (1): aluSrcA01, aluSrcB01, aluOp00 (branch target precompute). Next state by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other opcode -> FETCH (instruction skipped, no writes)
  - MEMADR (2): aluSrcA10, aluSrcB01, aluOp00. op 0000011 -> MEMREAD, else -> MEMWRITE
  - MEMREAD (3): resultSrc00, adrSrc1 -> MEMWB
  - MEMWB (4): resultSrc01, regWrite1 -> FETCH
  - MEMWRITE (5): resultSrc00, adrSrc1, memWrite1 -> FETCH
  - EXECUTER (6): aluSrcA10, aluSrcB00, aluOp10 -> ALUWB
  - EXECUTEI (8): aluSrcA10, aluSrcB01, aluOp10 -> ALUWB
  - ALUWB (7): resultSrc00, regWrite1 -> FETCH
  - JAL (9): aluSrcA01, aluSrcB10, aluOp00, resultSrc00, pcUpdate1 -> ALUWB
  - BEQ (10): aluSrcA10, aluSrcB00, aluOp01, resultSrc00, branch1 -> FETCH
- Unused encodings 11–15 -> FETCH next cycle, all outputs 0.
- immSrc from op:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all else -> 00

## Timing
- Reset asserted: state = FETCH immediately (async). Outputs are FETCH values: irWrite=1, pcWrite=1, aluSrcB=10, resultSrc=10, all others 0.
- First fetch completes on the first rising edge after reset deasserts.
- Reset mid-instruction: the in-flight instruction is abandoned. No regWrite/memWrite is asserted after reset rises.
- Cycles per instruction, FETCH to FETCH:
  - lw 5
  - sw, R, I, jal 4
  - beq 3
  - illegal opcode 2
- op is sampled only in DECODE and MEMADR. It is stable there because irWrite is only high in FETCH.
- pcWrite in BEQ follows zero combinationally within the cycle. Taken branch loads the PC at the end of BEQ.
- memWrite and regWrite are single-cycle pulses, never both high.

## Structure
- Package `riscv_mc_pkg` holds:
  - state enum (4-bit, encodings above);
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - select encodings for resultSrc, aluSrcA, aluSrcB, aluOp, immSrc.
- One sub-module `imm_src_deco` (combinational op -> immSrc). The FSM, output decode and pcWrite logic stay in this module.
- Sibling ALU decoder consumes aluOp. It is not instantiated here.

## Test plan
- Reset held 3 cycles, then released with op=0110011 -> FETCH outputs during reset; state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH; regWrite=1 only in ALUWB.
- op=0000011 -> 5-cycle sequence through MEMADR, MEMREAD, MEMWB; adrSrc=1 in MEMREAD; regWrite with resultSrc=01 in MEMWB.
- op=0100011 -> MEMWRITE reached in cycle 4 with memWrite=1, adrSrc=1; immSrc=01 throughout; no regWrite.
- op=1100011, zero=1 then repeat with zero=0 -> BEQ aluOp=01; pcWrite=1 in BEQ for zero=1, 0 for zero=0; back to FETCH after 3 cycles.
- op=1101111 -> JAL: pcWrite=1, aluSrcA=01, aluSrcB=10; then ALUWB regWrite=1; immSrc=11.
- op=1111111, then reset asserted mid-MEMADR of a lw -> illegal returns to FETCH after DECODE; async reset forces FETCH outputs before the next edge, with no memWrite/regWrite pulse.
